// File: rtl/cache_types_pkg.sv
// Shared types and constants for the cache line burst responder.
//
// LINE_W   : cache line width in bits
// BEAT_W   : memory beat width in bits
// ADDR_W   : address width in bits
// BEATS    : beats per line (power of two, at least 2)
// OFFSET_W : byte-offset bits inside a line, cleared on the burst address
// CNT_W    : width of the beat counter
package cache_types_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } responder_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  beat_idx_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index counter for one line burst. Counts modulo BEATS, so it wraps
// to 0 on the last beat by itself; clr forces it back to 0.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one beat
//   clr        : return to beat 0 (has priority over inc)
//   count      : current beat index
//   last       : current beat is the final beat of the line
module burst_beat_counter
  import cache_types_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      clr,
  output beat_idx_t count,
  output logic      last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == beat_idx_t'(BEATS - 1));

endmodule

// File: rtl/cacheline_burst_responder.sv
// Downstream responder for the cache arbiter's merged line request port.
// A full-line read or write is accepted in IDLE, executed as a burst of
// BEATS ascending beats on the memory interface, and acknowledged with a
// single-cycle line_resp_o pulse from the DONE state.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   line_read_i    : line read request (held until line_resp_o)
//   line_write_i   : line write request (held until line_resp_o), wins over read
//   line_addr_i    : line address, byte-offset bits ignored
//   line_wdata_i   : line data for writes
//   line_rdata_o   : assembled read line, valid in the response cycle
//   line_resp_o    : one-cycle completion pulse
//   burst_read_o   : memory read burst active
//   burst_write_o  : memory write burst active
//   burst_addr_o   : line-aligned burst address (0 when not bursting)
//   burst_wdata_o  : current write beat
//   burst_rdata_i  : current read beat
//   burst_resp_i   : memory beat acknowledge
module cacheline_burst_responder
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  input  line_t             line_wdata_i,
  output line_t             line_rdata_o,
  output logic              line_resp_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  output logic [ADDR_W-1:0] burst_addr_o,
  output beat_t             burst_wdata_o,
  input  beat_t             burst_rdata_i,
  input  logic              burst_resp_i
);

  responder_state_t  state;
  line_t             wdata_q;
  beat_idx_t         beat_idx;
  beat_idx_t         next_idx;
  logic              last_beat;
  logic              beat_ack;
  logic              cnt_clr;
  logic [ADDR_W-1:0] aligned_addr;
  logic              unused_addr_bits;

  assign aligned_addr     = {line_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_addr_bits = ^line_addr_i[OFFSET_W-1:0];

  // Acknowledges only count while a burst is in flight.
  assign beat_ack = burst_resp_i && ((state == READ) || (state == WRITE));
  assign cnt_clr  = (state == DONE);
  assign next_idx = beat_idx + 1'b1;

  burst_beat_counter u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (beat_ack),
    .clr   (cnt_clr),
    .count (beat_idx),
    .last  (last_beat)
  );

  // Write line copy; only ever read while a write burst is active, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && line_write_i) begin
      wdata_q <= line_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      line_rdata_o  <= '0;
      line_resp_o   <= 1'b0;
      burst_read_o  <= 1'b0;
      burst_write_o <= 1'b0;
      burst_addr_o  <= '0;
      burst_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          line_resp_o <= 1'b0;
          if (line_write_i) begin
            state         <= WRITE;
            burst_write_o <= 1'b1;
            burst_addr_o  <= aligned_addr;
            // Beat 0 is presented straight from the request so the first
            // write beat is valid in the first burst cycle.
            burst_wdata_o <= line_wdata_i[BEAT_W-1:0];
          end else if (line_read_i) begin
            state        <= READ;
            burst_read_o <= 1'b1;
            burst_addr_o <= aligned_addr;
          end
        end

        READ: begin
          if (burst_resp_i) begin
            line_rdata_o[int'(beat_idx)*BEAT_W +: BEAT_W] <= burst_rdata_i;
            if (last_beat) begin
              state        <= DONE;
              burst_read_o <= 1'b0;
              burst_addr_o <= '0;
              line_resp_o  <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (burst_resp_i) begin
            if (last_beat) begin
              state         <= DONE;
              burst_write_o <= 1'b0;
              burst_addr_o  <= '0;
              burst_wdata_o <= '0;
              line_resp_o   <= 1'b1;
            end else begin
              // Preload the next beat so it is on the bus the cycle after
              // the current one is acknowledged.
              burst_wdata_o <= wdata_q[int'(next_idx)*BEAT_W +: BEAT_W];
            end
          end
        end

        DONE: begin
          line_resp_o <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_responder.sv
module tb_cacheline_burst_responder;
  import cache_types_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_read_i = 1'b0;
  logic              line_write_i = 1'b0;
  logic [ADDR_W-1:0] line_addr_i = '0;
  line_t             line_wdata_i = '0;
  line_t             line_rdata_o;
  logic              line_resp_o;
  logic              burst_read_o;
  logic              burst_write_o;
  logic [ADDR_W-1:0] burst_addr_o;
  beat_t             burst_wdata_o;
  beat_t             burst_rdata_i = '0;
  logic              burst_resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cacheline_burst_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_read_i   (line_read_i),
    .line_write_i  (line_write_i),
    .line_addr_i   (line_addr_i),
    .line_wdata_i  (line_wdata_i),
    .line_rdata_o  (line_rdata_o),
    .line_resp_o   (line_resp_o),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_addr_o  (burst_addr_o),
    .burst_wdata_o (burst_wdata_o),
    .burst_rdata_i (burst_rdata_i),
    .burst_resp_i  (burst_resp_i)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    line_t       wline;
    line_t       rline;
    logic        exp_wr;
    logic [31:0] exp_addr;
    line_t       exp_rdata;
  } txn_t;

  txn_t tbl[4];

  function automatic beat_t rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " burst_read"}, burst_read_o, 1'b0);
    check({tag, " burst_write"}, burst_write_o, 1'b0);
    check({tag, " burst_addr"}, burst_addr_o, '0);
    check({tag, " burst_wdata"}, burst_wdata_o, '0);
  endtask

  // One complete transaction with an acknowledge every cycle.
  task automatic do_txn(input txn_t t);
    @(negedge clk);
    line_write_i = t.wr;
    line_read_i  = t.rd;
    line_addr_i  = t.addr;
    line_wdata_i = t.wline;
    burst_resp_i = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      check("txn burst_read", burst_read_o, !t.exp_wr);
      check("txn burst_write", burst_write_o, t.exp_wr);
      check("txn burst_addr", burst_addr_o, t.exp_addr);
      check("txn early resp", line_resp_o, 1'b0);
      if (t.exp_wr) check("txn burst_wdata", burst_wdata_o, t.wline[k*BEAT_W +: BEAT_W]);
      // Mid-burst changes to address/data must be ignored.
      if (k == 1) begin
        line_addr_i  = ~t.addr;
        line_wdata_i = ~t.wline;
      end
      burst_resp_i  = 1'b1;
      burst_rdata_i = t.rline[k*BEAT_W +: BEAT_W];
    end
    @(negedge clk);
    check("txn resp", line_resp_o, 1'b1);
    check("txn rdata", line_rdata_o, t.exp_rdata);
    check_idle_outputs("txn done");
    line_read_i   = 1'b0;
    line_write_i  = 1'b0;
    burst_resp_i  = 1'b0;
    burst_rdata_i = '0;
    @(negedge clk);
    check("txn resp width", line_resp_o, 1'b0);
    check_idle_outputs("txn after");
  endtask

  initial begin
    tbl[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1234, wline: '0,
               rline: {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)},
               exp_wr: 1'b0, exp_addr: 32'h0000_1220,
               exp_rdata: {64'h4444444444444444, 64'h3333333333333333,
                           64'h2222222222222222, 64'h1111111111111111}};
    tbl[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h8000_00E0,
               wline: {rep(8'hA3), rep(8'hA2), rep(8'hA1), rep(8'hA0)},
               rline: {4{64'h5A5A5A5A5A5A5A5A}},
               exp_wr: 1'b1, exp_addr: 32'h8000_00E0,
               exp_rdata: {64'h4444444444444444, 64'h3333333333333333,
                           64'h2222222222222222, 64'h1111111111111111}};
    tbl[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_005F,
               wline: {rep(8'hB3), rep(8'hB2), rep(8'hB1), rep(8'hB0)},
               rline: {4{64'hC3C3C3C3C3C3C3C3}},
               exp_wr: 1'b1, exp_addr: 32'h0000_0040,
               exp_rdata: {64'h4444444444444444, 64'h3333333333333333,
                           64'h2222222222222222, 64'h1111111111111111}};
    tbl[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF, wline: '0,
               rline: {64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978,
                       64'h8000000000000001, 64'h0123456789ABCDEF},
               exp_wr: 1'b0, exp_addr: 32'hFFFF_FFE0,
               exp_rdata: {64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978,
                           64'h8000000000000001, 64'h0123456789ABCDEF}};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset resp", line_resp_o, 1'b0);
    check("reset rdata", line_rdata_o, '0);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Acknowledges in IDLE are ignored and must not advance the beat index.
    burst_resp_i  = 1'b1;
    burst_rdata_i = 64'hBAD0BAD0BAD0BAD0;
    repeat (2) begin
      @(negedge clk);
      check("idle ack resp", line_resp_o, 1'b0);
      check("idle ack read", burst_read_o, 1'b0);
      check("idle ack rdata", line_rdata_o, '0);
    end
    burst_resp_i  = 1'b0;
    burst_rdata_i = '0;

    for (int i = 0; i < 4; i++) do_txn(tbl[i]);

    // Stalled memory: acknowledge every third cycle, junk on the bus otherwise.
    @(negedge clk);
    line_read_i = 1'b1;
    line_addr_i = 32'h0000_0100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("stall burst_read", burst_read_o, 1'b1);
      check("stall early resp", line_resp_o, 1'b0);
      check("stall addr", burst_addr_o, 32'h0000_0100);
      if (c % 3 == 2) begin
        burst_resp_i  = 1'b1;
        burst_rdata_i = rep(8'h55 + 8'(8'h11 * (c / 3)));
      end else begin
        burst_resp_i  = 1'b0;
        burst_rdata_i = 64'hDEADBEEFDEADBEEF;
      end
    end
    @(negedge clk);
    check("stall resp", line_resp_o, 1'b1);
    check("stall rdata", line_rdata_o,
          {64'h8888888888888888, 64'h7777777777777777,
           64'h6666666666666666, 64'h5555555555555555});
    line_read_i  = 1'b0;
    burst_resp_i = 1'b0;
    @(negedge clk);
    check("stall resp width", line_resp_o, 1'b0);

    // Asynchronous reset at beat 2 of a read.
    @(negedge clk);
    line_read_i = 1'b1;
    line_addr_i = 32'h0000_2000;
    @(negedge clk);
    burst_resp_i  = 1'b1;
    burst_rdata_i = rep(8'hC1);
    @(negedge clk);
    burst_rdata_i = rep(8'hC2);
    @(negedge clk);
    check("pre-reset burst_read", burst_read_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset resp", line_resp_o, 1'b0);
    check("async reset rdata", line_rdata_o, '0);
    check_idle_outputs("async reset");
    line_read_i  = 1'b0;
    burst_resp_i = 1'b0;
    @(negedge clk);
    check("in reset resp", line_resp_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset resp", line_resp_o, 1'b0);
    check_idle_outputs("post reset");
    do_txn('{wr: 1'b0, rd: 1'b1, addr: 32'h0000_3040, wline: '0,
             rline: {rep(8'hD4), rep(8'hD3), rep(8'hD2), rep(8'hD1)},
             exp_wr: 1'b0, exp_addr: 32'h0000_3040,
             exp_rdata: {64'hD4D4D4D4D4D4D4D4, 64'hD3D3D3D3D3D3D3D3,
                         64'hD2D2D2D2D2D2D2D2, 64'hD1D1D1D1D1D1D1D1}});

    // Back-to-back: write held to the response, then a read held across DONE.
    @(negedge clk);
    line_write_i = 1'b1;
    line_addr_i  = 32'h0000_4000;
    line_wdata_i = {rep(8'hE3), rep(8'hE2), rep(8'hE1), rep(8'hE0)};
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      check("b2b write", burst_write_o, 1'b1);
      check("b2b wdata", burst_wdata_o, rep(8'hE0 + 8'(k)));
      burst_resp_i = 1'b1;
    end
    @(negedge clk);
    check("b2b resp1", line_resp_o, 1'b1);
    line_write_i = 1'b0;
    line_read_i  = 1'b1;
    line_addr_i  = 32'h0000_5000;
    burst_resp_i = 1'b0;
    @(negedge clk);
    check("b2b gap resp", line_resp_o, 1'b0);
    check_idle_outputs("b2b gap");
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      check("b2b read", burst_read_o, 1'b1);
      check("b2b read addr", burst_addr_o, 32'h0000_5000);
      burst_resp_i  = 1'b1;
      burst_rdata_i = rep(8'hF1 + 8'(k));
    end
    @(negedge clk);
    check("b2b resp2", line_resp_o, 1'b1);
    check("b2b rdata", line_rdata_o,
          {64'hF4F4F4F4F4F4F4F4, 64'hF3F3F3F3F3F3F3F3,
           64'hF2F2F2F2F2F2F2F2, 64'hF1F1F1F1F1F1F1F1});
    line_read_i  = 1'b0;
    burst_resp_i = 1'b0;
    @(negedge clk);
    check("b2b resp2 width", line_resp_o, 1'b0);
    check_idle_outputs("b2b end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_responder.md
Name: cacheline_burst_responder

Overview:
- Downstream responder for the L1 cache arbiter's merged L2/memory request port.
- Accepts one full-line read or write from the arbiter and executes it as a fixed-length burst of beats to physical memory.
- Returns a single-cycle line response to the arbiter when the burst completes.
- Sits between the arbiter datapath and the memory burst interface.

Parameters:
LINE_W, 256, cache line width in bits
BEAT_W, 64, memory beat width in bits; LINE_W/BEAT_W = BEATS, a power of two ≥2
ADDR_W, 32, address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
line_read_i  in  1  arbiter line read request, held until line_resp_o
line_write_i  in  1  arbiter line write request, held until line_resp_o
line_addr_i  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored
line_wdata_i  in  LINE_W  write line data
line_rdata_o  out  LINE_W  assembled read line
line_resp_o  out  1  one-cycle completion pulse to arbiter
burst_read_o  out  1  memory read burst active
burst_write_o  out  1  memory write burst active
burst_addr_o  out  ADDR_W  line-aligned burst address
burst_wdata_o  out  BEAT_W  current write beat
burst_rdata_i  in  BEAT_W  current read beat
burst_resp_i  in  1  memory beat acknowledge, one per beat

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat count 0, line_rdata_o=0, line_resp_o=0, burst_read_o=0, burst_write_o=0, burst_addr_o=0, burst_wdata_o=0. Reset mid-burst aborts immediately; no response is issued.
- FSM states:
  - IDLE: if line_write_i, latch line_addr_i with the low 5 bits zeroed and latch line_wdata_i, then go to WRITE. Else if line_read_i, latch the aligned address and go to READ. Write wins if both are high. Otherwise stay in IDLE.
  - READ: burst_read_o=1. On each burst_resp_i, store burst_rdata_i into line_rdata_o bits [BEAT_W*k +: BEAT_W], where k is the beat count, then increment k. On the beat where k==BEATS-1 with burst_resp_i, go to DONE.
  - WRITE: burst_write_o=1. burst_wdata_o = latched line bits [BEAT_W*k +: BEAT_W]. k increments on burst_resp_i. Last beat goes to DONE.
  - DONE: line_resp_o=1 for exactly one cycle, burst_* deasserted, k cleared, then go to IDLE.
- burst_addr_o holds the latched aligned address for the whole burst and is 0 in IDLE.
- burst_read_o and burst_write_o stay asserted continuously across all beats. They are never both 1.
- Beat order is ascending: beat 0 is the LSBs.
- The beat counter is log2(BEATS) bits and wraps to 0 after the last beat.
- burst_resp_i outside READ/WRITE is ignored.
- line_rdata_o is valid in the DONE cycle. It holds until the next read's first beat; writes leave it unchanged.
- Request and address changes during a burst are ignored (latched copy is used).
- Min latency from request in IDLE to line_resp_o: 1 (accept) + BEATS (beats, given burst_resp_i every cycle) + 1 (DONE) = 6 cycles for defaults.
- A request still high in the cycle after DONE is accepted as a new transaction. The arbiter/cache must drop or change requests at the response edge.

Decomposition:
- Shared package cache_types_pkg:
  - constants LINE_W, BEAT_W, ADDR_W, BEATS, OFFSET_W=log2(LINE_W/8)
  - enum responder_state_t {IDLE, READ, WRITE, DONE}
  - typedefs line_t and beat_t
- Optional sub-module burst_beat_counter: BEATS-modulo counter with inc/clr and a last flag. The remaining logic stays in one module.

Test Plan:
- Read: line_read_i, addr 0x0000_1234. Expect burst_addr_o=0x0000_1220. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Expect line_resp_o on cycle 6 and line_rdata_o = {0x44..,0x33..,0x22..,0x11..}.
- Write: line_write_i, addr 0x8000_00E0, data with beat k = 0xA0+k replicated. Expect burst_wdata_o sequence 0xA0.., 0xA1.., 0xA2.., 0xA3.. with burst_write_o steady high, and one resp pulse.
- Stalled memory: burst_resp_i high only every 3rd cycle. Expect burst_read_o held, beats captured only on resp cycles, line_resp_o after the 4th acknowledge, pulse width 1.
- Simultaneous read+write in IDLE. Expect a WRITE burst, burst_read_o never high. Reads with stale rdata unchanged.
- Async reset asserted at beat 2 of a read. Expect all outputs 0 immediately, no line_resp_o. After release, a new read completes correctly from beat 0.
- Back-to-back: write then read held across DONE. Expect two separate bursts, one idle cycle between, two resp pulses.
